// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM with MemReady stalls,
// immediate-format decoder and ALU decoder.
module multicycle_ctrl (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state, next_state;
  logic [1:0] aluop;
  logic       branch, pcupdate, irwrite, memwrite, regwrite;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state    = FETCH;
    aluop         = 2'b00;
    branch        = 1'b0;
    pcupdate      = 1'b0;
    irwrite       = 1'b0;
    memwrite      = 1'b0;
    regwrite      = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    unique case (state)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        irwrite       = bus.MemReady;
        pcupdate      = bus.MemReady;
        next_state    = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next_state  = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        next_state = bus.MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        regwrite      = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        memwrite   = 1'b1;
        next_state = bus.MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        aluop       = 2'b10;
        next_state  = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        aluop       = 2'b10;
        next_state  = ALUWB;
      end
      ALUWB: regwrite = 1'b1;
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        aluop       = 2'b01;
        branch      = 1'b1;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pcupdate    = 1'b1;
        next_state  = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  // Reset masks every write enable immediately, so an aborted store never
  // reaches memory in the reset cycle.
  assign bus.PCWrite  = ((branch & bus.Zero) | pcupdate) & ~reset;
  assign bus.IRWrite  = irwrite  & ~reset;
  assign bus.MemWrite = memwrite & ~reset;
  assign bus.RegWrite = regwrite & ~reset;
  assign bus.State    = state;

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) may turn funct3=000 into sub; addi stays add.
  always_comb begin
    bus.ALUControl = 3'b000;
    case (aluop)
      2'b01: bus.ALUControl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
      default: bus.ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into its expected cycle
// trace, played into the controller and compared on every falling edge.
module tb_multicycle_ctrl;

  typedef struct {
    logic [3:0] st;
    logic       rst, mr, z;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
  } step_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0;
  logic reset;
  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  step_t      bq[$];
  step_t      exp_q[$];
  logic [3:0] obs[$];
  logic [1:0] cur_imm = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      step_t e;
      e = exp_q.pop_front();
      obs.push_back(bus.State);
      check("State",      32'(bus.State),      32'(e.st));
      check("PCWrite",    32'(bus.PCWrite),    32'(e.pcw));
      check("AdrSrc",     32'(bus.AdrSrc),     32'(e.adr));
      check("MemWrite",   32'(bus.MemWrite),   32'(e.memw));
      check("IRWrite",    32'(bus.IRWrite),    32'(e.irw));
      check("RegWrite",   32'(bus.RegWrite),   32'(e.regw));
      check("ResultSrc",  32'(bus.ResultSrc),  32'(e.res));
      check("ALUSrcA",    32'(bus.ALUSrcA),    32'(e.sa));
      check("ALUSrcB",    32'(bus.ALUSrcB),    32'(e.sb));
      check("ImmSrc",     32'(bus.ImmSrc),     32'(e.imm));
      check("ALUControl", 32'(bus.ALUControl), 32'(e.alu));
    end
  end

  // Instruction-level reference rules.
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic step_t base(input logic [3:0] st);
    step_t s;
    s = '{st: st, rst: 1'b0, mr: 1'b1, z: 1'b0, pcw: 1'b0, adr: 1'b0, memw: 1'b0,
          irw: 1'b0, regw: 1'b0, res: 2'b00, sa: 2'b00, sb: 2'b00, imm: cur_imm, alu: 3'b000};
    return s;
  endfunction

  task automatic add_fetch(input int waits, input logic rst);
    step_t s;
    s = base(4'd0);
    s.sb = 2'b10; s.res = 2'b10; s.rst = rst;
    for (int i = 0; i < waits; i++) begin
      s.mr = 1'b0;
      bq.push_back(s);
    end
    s.mr = 1'b1; s.irw = !rst; s.pcw = !rst;
    bq.push_back(s);
  endtask

  task automatic add_aluwb();
    step_t s;
    s = base(4'd8); s.regw = 1'b1;
    bq.push_back(s);
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int fw, input int mw, input logic zero, input logic rst_mw);
    step_t s;
    cur_imm = imm_of(op);
    add_fetch(fw, 1'b0);
    s = base(4'd1); s.sa = 2'b01; s.sb = 2'b01; s.z = 1'b1;  // Zero must not leak into PCWrite
    bq.push_back(s);
    if (op == LW || op == SW) begin
      s = base(4'd2); s.sa = 2'b10; s.sb = 2'b01;
      bq.push_back(s);
      if (op == LW) begin
        s = base(4'd3); s.adr = 1'b1;
        for (int i = 0; i < mw; i++) begin s.mr = 1'b0; bq.push_back(s); end
        s.mr = 1'b1; bq.push_back(s);
        s = base(4'd4); s.res = 2'b01; s.regw = 1'b1;
        bq.push_back(s);
      end else begin
        s = base(4'd5); s.adr = 1'b1; s.memw = 1'b1;
        for (int i = 0; i < mw; i++) begin s.mr = 1'b0; bq.push_back(s); end
        if (rst_mw) begin s.rst = 1'b1; s.memw = 1'b0; s.mr = 1'b0; end
        else s.mr = 1'b1;
        bq.push_back(s);
      end
    end else if (op == RT || op == IT) begin
      s = base(op == RT ? 4'd6 : 4'd7);
      s.sa = 2'b10; s.sb = (op == RT) ? 2'b00 : 2'b01; s.alu = alu_of(op, f3, f7);
      bq.push_back(s);
      add_aluwb();
    end else if (op == BQ) begin
      s = base(4'd9); s.sa = 2'b10; s.alu = 3'b001; s.z = zero; s.pcw = zero;
      bq.push_back(s);
    end else if (op == JL) begin
      s = base(4'd10); s.sa = 2'b01; s.sb = 2'b10; s.pcw = 1'b1;
      bq.push_back(s);
      add_aluwb();
    end
  endtask

  task automatic play(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    obs.delete();
    foreach (bq[i]) begin
      @(posedge clk); #1;
      if (i == 0) begin bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; end
      reset = bq[i].rst; bus.MemReady = bq[i].mr; bus.Zero = bq[i].z;
      exp_q.push_back(bq[i]);
    end
    @(negedge clk); #1;
    bq.delete();
  endtask

  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input int fw, input int mw, input logic zero, input logic rst_mw, input int exp_len);
    build(op, f3, f7, fw, mw, zero, rst_mw);
    check({name, "_len"}, 32'(bq.size()), 32'(exp_len));
    play(op, f3, f7);
  endtask

  task automatic check_seq(input string name, input logic [3:0] seq[]);
    foreach (seq[i]) begin
      if (i < obs.size()) check(name, 32'(obs[i]), 32'(seq[i]));
      else check({name, "_missing"}, 32'(obs.size()), 32'(i + 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0; bus.MemReady = 1'b1;
    @(posedge clk);
    // Two reset cycles: FETCH outputs with every write enable masked.
    add_fetch(0, 1'b1);
    add_fetch(0, 1'b1);
    bq[0].z = 1'b1;
    play(7'd0, 3'd0, 1'b0);
    check("reset_state", 32'(obs[0]), 32'd0);

    run("sub", RT, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, 4);
    check_seq("sub_seq", '{4'd0, 4'd1, 4'd6, 4'd8});
    run("slt", RT, 3'b010, 1'b0, 0, 0, 1'b0, 1'b0, 4);
    run("or",  RT, 3'b110, 1'b1, 0, 0, 1'b0, 1'b0, 4);
    run("lw",  LW, 3'b010, 1'b0, 0, 3, 1'b0, 1'b0, 8);
    check_seq("lw_seq", '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4});
    run("lw0", LW, 3'b010, 1'b0, 0, 0, 1'b0, 1'b0, 5);
    run("beq_t", BQ, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0, 3);
    run("beq_n", BQ, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 3);
    run("jal", JL, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 4);
    check_seq("jal_seq", '{4'd0, 4'd1, 4'd10, 4'd8});
    run("addi", IT, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, 4);
    run("andi", IT, 3'b111, 1'b0, 0, 0, 1'b0, 1'b0, 4);
    run("sw",  SW, 3'b010, 1'b0, 1, 2, 1'b0, 1'b0, 7);
    run("sw_rst", SW, 3'b010, 1'b0, 0, 1, 1'b0, 1'b1, 5);
    run("bad", 7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 2);
    check_seq("bad_seq", '{4'd0, 4'd1});
    // Trailing stalled fetch confirms the return to FETCH after the illegal op.
    add_fetch(1, 1'b0);
    play(7'b1111111, 3'b000, 1'b0);
    check_seq("tail_seq", '{4'd0, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It contains a Moore FSM that sequences the shared ALU and the unified instruction/data memory port over several cycles per instruction, an instruction-type immediate decoder and an ALU decoder. It sits beside the multicycle datapath and drives its mux selects and write enables. A MemReady handshake lets slow memory stall fetch and data accesses.

Parameters:
None. Encodings are fixed.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory has completed the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register and OldPC enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  ALU B select: 00=RD2, 01=ImmExt, 10=constant 4
ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
ALUControl  output  3  000=add, 001=sub, 010=and, 011=or, 101=slt
RegWrite  output  1  register file write enable
State  output  4  current FSM state (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10.
- On a clk edge with reset=1, the state becomes FETCH.
- While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0, regardless of state.
- Every output not listed for a state below is 0. This includes don't-care selects, so there are no X values on outputs.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=MemReady and PCUpdate=MemReady.
  - If MemReady=1, go to DECODE; otherwise stay in FETCH with no writes.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch/jump target PC+imm.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other op -> FETCH. Nothing is written, and the PC has already advanced by 4.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Wait in MEMREAD until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - MemWrite stays high while waiting for MemReady.
  - Go to FETCH in the cycle MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state: ALUWB.
- Unused state encodings 11–15 go to FETCH on the next edge with all outputs 0.
- PCWrite = (Branch & Zero) | PCUpdate. This is the only output that depends combinationally on Zero.
- ImmSrc is decoded combinationally from op, independent of state: sw -> 01, beq -> 10, jal -> 11, everything else -> 00.
- ALU decoder:
  - ALUOp=00 -> add; ALUOp=01 -> sub.
  - ALUOp=10 by funct3:
    - 000: sub if (op[5] & funct7b5), else add. addi is therefore never sub.
    - 010 -> slt; 110 -> or; 111 -> and.
    - Any other funct3 -> add.
  - ALUOp=11 -> add.
- Latency with MemReady tied to 1: beq 3 cycles; R-type, I-type, sw and jal 4 cycles; lw 5 cycles.
- Each memory wait cycle adds exactly one cycle to the instruction.
- Reset asserted mid-instruction (e.g. in MEMWRITE) aborts the instruction. The write enables drop in the reset cycle itself, and the FSM is in FETCH after the edge.

Test Plan:
- Reset for 2 cycles, then MemReady=1 and op=0110011, funct3=000, funct7b5=1: state sequence 0,1,6,8,0. ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- op=0000011 (lw), MemReady low for 3 cycles in MEMREAD: sequence 0,1,2,3,3,3,3,4,0 (8 cycles). AdrSrc=1 throughout MEMREAD; RegWrite=1 with ResultSrc=01 in MEMWB only.
- op=1100011 (beq), run twice with Zero=1 then Zero=0 in BEQ: PCWrite=1 then PCWrite=0 in BEQ. ALUControl=001 and ImmSrc=10 in both runs.
- op=1101111 (jal): sequence 0,1,10,8,0. In JAL: PCWrite=1, ALUSrcA=01, ALUSrcB=10. ImmSrc=11.
- op=0010011 with funct3=000 and funct7b5=1 (addi): ALUControl=000. Then op=0010011 with funct3=111: ALUControl=010.
- op=0100011 (sw) with reset asserted during MEMWRITE: MemWrite=0 in the reset cycle and State=0 afterwards. Separately, op=1111111 gives sequence 0,1,0 with no RegWrite or MemWrite.
